slice_param: RTL and testbench

//  Parametrised successor of the 7-series-style slice: NUM_LANES LUT lanes, each a 2^K-entry LUT, carry cell,

---
 rtl/slice_param_pkg.sv | 59 +++++
 rtl/slice_lane.sv | 73 +++++++
 rtl/slice_param.sv | 157 +++++++++++++++
 tb/tb_slice_param.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_param_pkg.sv
// rtl/slice_param_pkg.sv - field offsets, encodings and sizing helpers for slice_param
// Frame layout, LSB first:
//   lane i at i*lane_bits(K): LUT[2^K-1:0], DSEL[1:0], OSEL[1:0]
//   then CE_INV, SR_INV, CSRC[1:0], SRVAL
package slice_param_pkg;

  // Per-lane fields; the LUT table always sits at lane offset 0.
  function automatic int lane_bits(input int k);
    return (1 << k) + 4;
  endfunction

  function automatic int dsel_off(input int k);
    return (1 << k);
  endfunction

  function automatic int osel_off(input int k);
    return (1 << k) + 2;
  endfunction

  // Slice-wide fields, relative to the end of the last lane.
  localparam int CE_INV_OFF  = 0;
  localparam int SR_INV_OFF  = 1;
  localparam int CSRC_OFF    = 2;
  localparam int SRVAL_OFF   = 4;
  localparam int GLOBAL_BITS = 5;

  function automatic int cfg_bits(input int num_lanes, input int k);
    return num_lanes * lane_bits(k) + GLOBAL_BITS;
  endfunction

  function automatic int cfg_words(input int num_lanes, input int k, input int cfg_w);
    return (cfg_bits(num_lanes, k) + cfg_w - 1) / cfg_w;
  endfunction

  // Carry-in source of lane 0
  localparam logic [1:0] CSRC_CIN  = 2'b00;
  localparam logic [1:0] CSRC_X0   = 2'b01;
  localparam logic [1:0] CSRC_ZERO = 2'b10;
  localparam logic [1:0] CSRC_ONE  = 2'b11;

  // Combinational output select
  localparam logic [1:0] OSEL_S  = 2'b00;
  localparam logic [1:0] OSEL_CO = 2'b01;
  localparam logic [1:0] OSEL_F7 = 2'b10;
  localparam logic [1:0] OSEL_O  = 2'b11;

  // Flip-flop D select
  localparam logic [1:0] DSEL_O  = 2'b00;
  localparam logic [1:0] DSEL_S  = 2'b01;
  localparam logic [1:0] DSEL_X  = 2'b10;
  localparam logic [1:0] DSEL_F7 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/slice_lane.sv
// rtl/slice_lane.sv - one slice lane: LUT, carry cell, output/D muxes and flip-flop
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (clears q)
//   addr, lut       LUT address and table from the active frame
//   dsel, osel      D and combinational output selects
//   x, ci, f7       lane bypass input, carry in, pair F7 result
//   ce, sr, srval   polarity-corrected enable and set/reset, set/reset value
//   o, omux, q      LUT output, selected combinational output, FF output
module slice_lane
  import slice_param_pkg::*;
#(
  parameter int K = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [K-1:0]      addr,
  input  logic [(1<<K)-1:0] lut,
  input  logic [1:0]        dsel,
  input  logic [1:0]        osel,
  input  logic              x,
  input  logic              ci,
  input  logic              f7,
  input  logic              ce,
  input  logic              sr,
  input  logic              srval,
  output logic              o,
  output logic              omux,
  output logic              q
);

  logic s;
  logic co;
  logic d;

  // The LUT output doubles as the propagate term; x is the generate value.
  assign o  = lut[addr];
  assign s  = o ^ ci;
  assign co = o ? ci : x;

  always_comb begin
    omux = s;
    case (osel)
      OSEL_S:  omux = s;
      OSEL_CO: omux = co;
      OSEL_F7: omux = f7;
      OSEL_O:  omux = o;
      default: omux = s;
    endcase
  end

  always_comb begin
    d = o;
    case (dsel)
      DSEL_O:  d = o;
      DSEL_S:  d = s;
      DSEL_X:  d = x;
      DSEL_F7: d = f7;
      default: d = o;
    endcase
  end

  // Set/reset wins over the enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (sr) begin
      q <= srval;
    end else if (ce) begin
      q <= d;
    end
  end

endmodule

// File: rtl/slice_param.sv
// rtl/slice_param.sv - parametrised slice with atomic word-wide configuration loader
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   lut_in                          lane i LUT address = lut_in[i*K +: K]
//   X, CE, SR, CIN                  lane bypass, FF enable, FF set/reset, carry in
//   COUT, O, Q, OMUX                carry out, LUT outputs, FF outputs, selected outputs
//   cfg_data, cfg_valid, cfg_ready  config word stream, word 0 = frame LSBs
//   cfg_abort                       drop the partially loaded frame
//   cfg_busy, cfg_done              frame in flight, one-cycle commit pulse
module slice_param
  import slice_param_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int K         = 6,
  parameter int CFG_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_LANES*K-1:0] lut_in,
  input  logic [NUM_LANES-1:0]   X,
  input  logic                   CE,
  input  logic                   SR,
  input  logic                   CIN,
  output logic                   COUT,
  output logic [NUM_LANES-1:0]   O,
  output logic [NUM_LANES-1:0]   Q,
  output logic [NUM_LANES-1:0]   OMUX,
  input  logic [CFG_W-1:0]       cfg_data,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic                   cfg_abort,
  output logic                   cfg_busy,
  output logic                   cfg_done
);

  localparam int LUT_N     = 1 << K;
  localparam int LANE_BITS = lane_bits(K);
  localparam int DSEL_OFF  = dsel_off(K);
  localparam int OSEL_OFF  = osel_off(K);
  localparam int LANES_END = NUM_LANES * LANE_BITS;
  localparam int CFG_BITS  = cfg_bits(NUM_LANES, K);
  localparam int CFG_WORDS = cfg_words(NUM_LANES, K, CFG_W);
  localparam int CNT_W     = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(CFG_WORDS - 1);

  cfg_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CFG_BITS-1:0] shadow_q;
  logic [CFG_BITS-1:0] active_q;
  logic                accept;

  assign cfg_ready = rst_n && (state_q != ST_COMMIT);
  assign cfg_busy  = (state_q == ST_LOAD) || (state_q == ST_COMMIT);
  assign accept    = cfg_valid && cfg_ready;

  // Words fill the shadow frame; the active frame only changes on the
  // commit edge, so the datapath never sees a partially written frame.
  // Padding bits of the last word have no storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (cfg_abort) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (accept) begin
            for (int b = 0; b < CFG_BITS; b++) begin
              if (b / CFG_W == int'(cnt_q)) begin
                shadow_q[b] <= cfg_data[b % CFG_W];
              end
            end
            if (cnt_q == LAST_WORD) begin
              cnt_q   <= '0;
              state_q <= ST_COMMIT;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= ST_LOAD;
            end
          end
        end
        ST_COMMIT: begin
          active_q <= shadow_q;
          cfg_done <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic                 ce_eff;
  logic                 sr_eff;
  logic                 carry;
  logic [NUM_LANES-1:0] ci;
  logic [NUM_LANES-1:0] f7;

  assign ce_eff = CE ^ active_q[LANES_END + CE_INV_OFF];
  assign sr_eff = SR ^ active_q[LANES_END + SR_INV_OFF];

  // Ripple carry: each lane passes ci when its LUT output propagates,
  // otherwise it generates X[i].
  always_comb begin
    carry = 1'b0;
    case (active_q[LANES_END + CSRC_OFF +: 2])
      CSRC_CIN:  carry = CIN;
      CSRC_X0:   carry = X[0];
      CSRC_ZERO: carry = 1'b0;
      CSRC_ONE:  carry = 1'b1;
      default:   carry = 1'b0;
    endcase
    ci = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      ci[i] = carry;
      carry = O[i] ? carry : X[i];
    end
    COUT = carry;
  end

  // F7 of a lane pair is selected by the even lane's X and shared by both lanes.
  for (genvar j = 0; j < NUM_LANES / 2; j++) begin : g_pair
    logic f7_pair;
    assign f7_pair     = X[2*j] ? O[2*j+1] : O[2*j];
    assign f7[2*j]     = f7_pair;
    assign f7[2*j+1]   = f7_pair;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam int BASE = i * LANE_BITS;
    slice_lane #(
      .K(K)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (lut_in[i*K +: K]),
      .lut   (active_q[BASE +: LUT_N]),
      .dsel  (active_q[BASE + DSEL_OFF +: 2]),
      .osel  (active_q[BASE + OSEL_OFF +: 2]),
      .x     (X[i]),
      .ci    (ci[i]),
      .f7    (f7[i]),
      .ce    (ce_eff),
      .sr    (sr_eff),
      .srval (active_q[LANES_END + SRVAL_OFF]),
      .o     (O[i]),
      .omux  (OMUX[i]),
      .q     (Q[i])
    );
  end

endmodule

// File: tb/tb_slice_param.sv
// tb/tb_slice_param.sv - self-checking bench for slice_param at default parameters
module tb_slice_param;

  localparam int NL = 4;
  localparam int K  = 6;
  localparam int CW = 32;
  localparam int LB = 68;
  localparam int GB = NL * LB;
  localparam int CB = GB + 5;
  localparam int NW = 9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NL*K-1:0] lut_in = '0;
  logic [NL-1:0]   X = '0;
  logic            CE = 1'b0;
  logic            SR = 1'b0;
  logic            CIN = 1'b0;
  logic            COUT;
  logic [NL-1:0]   O;
  logic [NL-1:0]   Q;
  logic [NL-1:0]   OMUX;
  logic [CW-1:0]   cfg_data = '0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic            cfg_abort = 1'b0;
  logic            cfg_busy;
  logic            cfg_done;

  always #5 clk = ~clk;

  slice_param #(.NUM_LANES(NL), .K(K), .CFG_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .lut_in(lut_in), .X(X), .CE(CE), .SR(SR), .CIN(CIN),
    .COUT(COUT), .O(O), .Q(Q), .OMUX(OMUX),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_abort(cfg_abort), .cfg_busy(cfg_busy), .cfg_done(cfg_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [CB-1:0] m_active;
  logic [CW-1:0] m_shadow [NW];
  int            m_held;
  bit            m_commit;
  bit            m_done;
  logic [NL-1:0] m_q;
  bit            started = 0;

  function automatic void model_comb(output logic [NL-1:0] o, output logic [NL-1:0] om,
                                     output logic [NL-1:0] d, output logic cout);
    logic [1:0] csrc, osel, dsel;
    logic c, s, co, f7;
    int a, pb;
    for (int i = 0; i < NL; i++) begin
      a = int'(lut_in[i*K +: K]);
      o[i] = m_active[i*LB + a];
    end
    csrc = m_active[GB+2 +: 2];
    c = (csrc == 2'd0) ? CIN : (csrc == 2'd1) ? X[0] : (csrc == 2'd2) ? 1'b0 : 1'b1;
    for (int i = 0; i < NL; i++) begin
      pb   = i & ~1;
      f7   = X[pb] ? o[pb+1] : o[pb];
      s    = o[i] ^ c;
      co   = o[i] ? c : X[i];
      dsel = m_active[i*LB + 64 +: 2];
      osel = m_active[i*LB + 66 +: 2];
      om[i] = (osel == 2'd0) ? s : (osel == 2'd1) ? co : (osel == 2'd2) ? f7 : o[i];
      d[i]  = (dsel == 2'd0) ? o[i] : (dsel == 2'd1) ? s : (dsel == 2'd2) ? X[i] : f7;
      c = co;
    end
    cout = c;
  endfunction

  always @(posedge clk) begin
    logic [NL-1:0] o, om, d;
    logic cout;
    model_comb(o, om, d, cout);
    if (!rst_n) begin
      m_q = '0;
      m_active = '0;
      m_held = 0;
      m_commit = 0;
      m_done = 0;
    end else begin
      if (SR ^ m_active[GB+1]) m_q = {NL{m_active[GB+4]}};
      else if (CE ^ m_active[GB]) m_q = d;
      m_done = m_commit;
      if (m_commit) begin
        for (int b = 0; b < CB; b++) m_active[b] = m_shadow[b/CW][b%CW];
        m_commit = 0;
      end else if (cfg_abort) begin
        m_held = 0;
      end else if (cfg_valid) begin
        m_shadow[m_held] = cfg_data;
        m_held++;
        if (m_held == NW) begin
          m_held = 0;
          m_commit = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [NL-1:0] o, om, d;
    logic cout;
    if (started) begin
      model_comb(o, om, d, cout);
      check("O", O, o);
      check("OMUX", OMUX, om);
      check("COUT", COUT, cout);
      check("Q", Q, m_q);
      check("cfg_ready", cfg_ready, rst_n && !m_commit);
      check("cfg_busy", cfg_busy, (m_held > 0) || m_commit);
      check("cfg_done", cfg_done, m_done);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [NW*CW-1:0] fr;
  logic [CW-1:0]    words [2*NW];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [63:0] lut, input logic [1:0] dsel,
                          input logic [1:0] osel);
    fr[i*LB +: 64]    = lut;
    fr[i*LB + 64 +: 2] = dsel;
    fr[i*LB + 66 +: 2] = osel;
  endtask

  task automatic set_glob(input logic ce_inv, input logic sr_inv, input logic [1:0] csrc,
                          input logic srval);
    fr[GB]       = ce_inv;
    fr[GB+1]     = sr_inv;
    fr[GB+2 +: 2] = csrc;
    fr[GB+4]     = srval;
  endtask

  task automatic send_words(input int n);
    for (int w = 0; w < n; w++) begin
      cfg_data  = fr[w*CW +: CW];
      cfg_valid = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic send_frame();
    send_words(NW);
    tick();
  endtask

  function automatic logic [NL*K-1:0] add_in(input logic [3:0] a, input logic [3:0] b);
    logic [NL*K-1:0] v = '0;
    for (int i = 0; i < NL; i++) begin
      v[i*K]   = a[i];
      v[i*K+1] = b[i];
    end
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pa [4] = '{7, 15, 3, 9};
    int pb [4] = '{1, 1, 4, 9};
    int k, low, dones, sum;
    logic acc;

    // 1: reset with inputs toggling
    @(posedge clk);
    #1 started = 1;
    X = 4'hA; SR = 1'b1; CE = 1'b1;
    tick();
    X = 4'h5; SR = 1'b0; CE = 1'b0;
    check("t1_q_reset", Q, 4'h0);
    check("t1_ready_in_reset", cfg_ready, 1'b0);
    check("t1_busy_reset", cfg_busy, 1'b0);
    check("t1_done_reset", cfg_done, 1'b0);
    rst_n = 1'b1;
    X = 4'h0;
    #1 check("t1_ready_after", cfg_ready, 1'b1);
    tick();

    // 2: parity LUT on lane 0
    fr = '0;
    set_lane(0, 64'h6996966996696996, 2'b00, 2'b11);
    send_frame();
    check("t2_done_pulse", cfg_done, 1'b1);
    CE = 1'b1;
    lut_in = 24'h000001;
    #1 check("t2_o_par1", O[0], 1'b1);
    tick();
    check("t2_q_par1", Q[0], 1'b1);
    lut_in = 24'h000003;
    #1 check("t2_o_par0", O[0], 1'b0);
    tick();

    // 3: 4-bit adder
    fr = '0;
    for (int i = 0; i < NL; i++) set_lane(i, 64'h6666666666666666, 2'b00, 2'b00);
    set_glob(1'b0, 1'b0, 2'b10, 1'b0);
    send_frame();
    lut_in = add_in(4'd7, 4'd1); X = 4'd7;
    #1 check("t3_sum_7_1", OMUX, 4'b1000);
    check("t3_cout_7_1", COUT, 1'b0);
    lut_in = add_in(4'd15, 4'd1); X = 4'd15;
    #1 check("t3_sum_15_1", OMUX, 4'b0000);
    check("t3_cout_15_1", COUT, 1'b1);
    for (int t = 0; t < 4; t++) begin
      lut_in = add_in(4'(pa[t]), 4'(pb[t]));
      X = 4'(pa[t]);
      sum = pa[t] + pb[t];
      #1 check("t3_sum_arith", OMUX, 32'(sum % 16));
      check("t3_cout_arith", COUT, 32'(sum / 16));
    end
    tick();
    set_glob(1'b0, 1'b0, 2'b11, 1'b0);
    send_frame();
    lut_in = add_in(4'd0, 4'd0); X = 4'd0;
    #1 check("t3_sum_cin1", OMUX, 4'b0001);
    tick();

    // 4: shadow isolation and abort
    lut_in = {4{6'd3}};
    fr = '0;
    for (int i = 0; i < NL; i++) set_lane(i, 64'hFFFFFFFFFFFFFFFF, 2'b00, 2'b11);
    send_words(4);
    check("t4_busy_partial", cfg_busy, 1'b1);
    check("t4_o_unchanged", O, 4'h0);
    cfg_abort = 1'b1; cfg_valid = 1'b1; cfg_data = 32'hDEADBEEF;
    tick();
    cfg_abort = 1'b0; cfg_valid = 1'b0;
    check("t4_busy_abort", cfg_busy, 1'b0);
    check("t4_o_after_abort", O, 4'h0);
    fr = '0;
    for (int i = 0; i < NL; i++)
      set_lane(i, (i % 2 == 0) ? 64'h8888888888888888 : 64'h0, 2'b00, 2'b11);
    send_frame();
    check("t4_o_new_frame", O, 4'b0101);
    tick();

    // 5: CE/SR polarity
    CE = 1'b0; SR = 1'b0;
    fr = '0;
    for (int i = 0; i < NL; i++) set_lane(i, 64'h0, 2'b10, 2'b11);
    set_glob(1'b0, 1'b0, 2'b00, 1'b1);
    send_frame();
    SR = 1'b1;
    tick();
    check("t5_q_set", Q, 4'hF);
    SR = 1'b0; X = 4'b0011;
    tick();
    check("t5_q_hold", Q, 4'hF);
    set_glob(1'b0, 1'b1, 2'b00, 1'b1);
    send_frame();
    SR = 1'b1;
    tick();
    check("t5_q_srinv_hold", Q, 4'hF);
    CE = 1'b1;
    tick();
    check("t5_q_srinv_d", Q, 4'b0011);
    SR = 1'b0;
    tick();
    check("t5_q_srinv_set", Q, 4'hF);
    CE = 1'b0; SR = 1'b0; X = 4'h0;
    tick();
    tick();

    // 6: back-to-back frames with cfg_valid held high
    lut_in = '0;
    fr = '0;
    for (int i = 0; i < NL; i++) set_lane(i, 64'hFFFFFFFFFFFFFFFF, 2'b00, 2'b11);
    for (int w = 0; w < NW; w++) words[w] = fr[w*CW +: CW];
    fr = '0;
    set_lane(2, 64'hFFFFFFFFFFFFFFFF, 2'b00, 2'b11);
    for (int w = 0; w < NW; w++) words[NW + w] = fr[w*CW +: CW];
    k = 0; low = 0; dones = 0;
    for (int cyc = 0; cyc < 40 && k < 2*NW; cyc++) begin
      cfg_valid = 1'b1;
      cfg_data  = words[k];
      acc = cfg_ready;
      if (!acc) low++;
      tick();
      if (cfg_done) dones++;
      if (acc) k++;
    end
    cfg_valid = 1'b0;
    check("t6_words_accepted", k, 2*NW);
    for (int cyc = 0; cyc < 3; cyc++) begin
      tick();
      if (cfg_done) dones++;
    end
    check("t6_ready_low_cycles", low, 1);
    check("t6_done_pulses", dones, 2);
    check("t6_o_second_frame", O, 4'b0100);

    // 7: reset mid-load clears the active frame
    send_words(3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1 check("t7_o_zero", O, 4'h0);
    check("t7_busy_zero", cfg_busy, 1'b0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
